// File: rtl/shift_pkg.sv
// Shared types and constants for the shift sequencer and its barrel shifter.
// The helper decides whether a command needs the second shifter pass.
package shift_pkg;

  localparam int SHIFT_WIDTH = 32;

  typedef enum logic [1:0] {
    SHIFT_SLL = 2'b00,
    SHIFT_SRL = 2'b01,
    SHIFT_ROL = 2'b10,
    SHIFT_SRA = 2'b11
  } shift_op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    PASS1 = 2'b01,
    PASS2 = 2'b10,
    DONE  = 2'b11
  } seq_state_e;

  // ROL wraps the bits lost in pass 1; SRA only needs a sign mask for negative operands.
  function automatic logic needs_second_pass(input shift_op_e op,
                                             input logic amt_nz,
                                             input logic msb);
    case (op)
      SHIFT_ROL: return amt_nz;
      SHIFT_SRA: return amt_nz & msb;
      default:   return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/barrel_shifter.sv
// Combinational logical barrel shifter: dir=0 shifts left, dir=1 shifts right.
module barrel_shifter #(
  parameter  int WIDTH = 32,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] data_in,
  input  logic [SHW-1:0]   shift_amt,
  input  logic             dir,
  output logic [WIDTH-1:0] data_out
);

  // Zero-filling shift in the selected direction.
  always_comb begin
    data_out = {WIDTH{1'b0}};
    if (dir) begin
      data_out = data_in >> shift_amt;
    end else begin
      data_out = data_in << shift_amt;
    end
  end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle shift unit: SLL/SRL in one barrel_shifter pass, ROL/SRA in two,
// with a valid/ready command input and a registered valid/ready result.
module shift_sequencer
  import shift_pkg::*;
#(
  parameter  int WIDTH = SHIFT_WIDTH,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_amt,
  input  logic [1:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  seq_state_e       state_r;
  seq_state_e       next_state_s;
  logic [WIDTH-1:0] operand_r;
  logic [WIDTH-1:0] partial_r;
  logic [WIDTH-1:0] out_data_r;
  logic [SHW-1:0]   amt_r;
  shift_op_e        op_r;

  logic [WIDTH-1:0] bs_data_s;
  logic [WIDTH-1:0] bs_out_s;
  logic [SHW-1:0]   bs_amt_s;
  logic             bs_dir_s;
  logic             need_pass2_s;
  logic             accept_s;

  assign in_ready     = (state_r == IDLE);
  assign out_valid    = (state_r == DONE);
  assign out_data     = out_data_r;
  assign accept_s     = in_valid & in_ready;
  assign need_pass2_s = needs_second_pass(op_r, (amt_r != {SHW{1'b0}}), operand_r[WIDTH-1]);

  barrel_shifter #(.WIDTH(WIDTH)) u_barrel_shifter (
    .data_in   (bs_data_s),
    .shift_amt (bs_amt_s),
    .dir       (bs_dir_s),
    .data_out  (bs_out_s)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          next_state_s = PASS1;
        end else begin
          next_state_s = IDLE;
        end
      end
      PASS1: begin
        if (need_pass2_s) begin
          next_state_s = PASS2;
        end else begin
          next_state_s = DONE;
        end
      end
      PASS2: next_state_s = DONE;
      DONE: begin
        if (out_ready) begin
          next_state_s = IDLE;
        end else begin
          next_state_s = DONE;
        end
      end
      default: next_state_s = IDLE;
    endcase
  end

  // Shifter operand steering; idle states drive zeros.
  always_comb begin
    bs_data_s = {WIDTH{1'b0}};
    bs_amt_s  = {SHW{1'b0}};
    bs_dir_s  = 1'b0;
    case (state_r)
      PASS1: begin
        bs_data_s = operand_r;
        bs_amt_s  = amt_r;
        bs_dir_s  = (op_r == SHIFT_SRL) || (op_r == SHIFT_SRA);
      end
      PASS2: begin
        // WIDTH-amt truncated to SHW bits is simply the two's complement of amt.
        bs_amt_s = {SHW{1'b0}} - amt_r;
        if (op_r == SHIFT_SRA) begin
          bs_data_s = {WIDTH{1'b1}};
          bs_dir_s  = 1'b0;
        end else begin
          bs_data_s = operand_r;
          bs_dir_s  = 1'b1;
        end
      end
      default: begin
        bs_data_s = {WIDTH{1'b0}};
        bs_amt_s  = {SHW{1'b0}};
        bs_dir_s  = 1'b0;
      end
    endcase
  end

  // Command capture, partial result and output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      operand_r  <= {WIDTH{1'b0}};
      amt_r      <= {SHW{1'b0}};
      op_r       <= SHIFT_SLL;
      partial_r  <= {WIDTH{1'b0}};
      out_data_r <= {WIDTH{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            operand_r <= in_data;
            amt_r     <= in_amt;
            op_r      <= shift_op_e'(in_op);
          end
        end
        PASS1: begin
          partial_r <= bs_out_s;
          if (!need_pass2_s) begin
            out_data_r <= bs_out_s;
          end
        end
        PASS2: out_data_r <= partial_r | bs_out_s;
        default: begin
          out_data_r <= out_data_r;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench for shift_sequencer: directed cases plus a random sweep
// compared against a plain-arithmetic reference model.
module tb_shift_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = 32'h0;
  logic [4:0]  in_amt = 5'd0;
  logic [1:0]  in_op = 2'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;

  int n_checks = 0;
  int n_fail   = 0;

  shift_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_amt    (in_amt),
    .in_op     (in_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  always #5 clk = ~clk;

  // Reference: what each op means arithmetically.
  function automatic logic [31:0] ref_model(input logic [31:0] d, input int a, input int op);
    logic signed [31:0] sd;
    sd = d;
    case (op)
      0:       return d << a;
      1:       return d >> a;
      2:       return (a == 0) ? d : ((d << a) | (d >> (32 - a)));
      default: return 32'(sd >>> a);
    endcase
  endfunction

  // Samples after the accept edge until valid appears: 1 for single pass, 2 for two passes.
  function automatic int ref_lat(input logic [31:0] d, input int a, input int op);
    if ((op == 2 && a != 0) || (op == 3 && a != 0 && d[31])) return 2;
    return 1;
  endfunction

  // Presents a command and returns once it has been accepted (sample point after accept edge).
  task automatic send(input logic [31:0] d, input logic [4:0] a, input logic [1:0] op, output bit ok);
    in_data = d; in_amt = a; in_op = op; in_valid = 1'b1; ok = 1'b0;
    for (int c = 0; c < 20 && !ok; c++) begin
      if (in_ready === 1'b1) ok = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  // Steps until out_valid is seen; lat=-1 on timeout.
  task automatic run_to_valid(output int lat, output logic [31:0] data);
    bit found;
    lat = -1; data = 32'h0; found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      if (out_valid === 1'b1) begin
        lat = c; data = out_data; found = 1'b1;
      end else begin
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_reset;
    #22;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_checks++; if (out_data !== 32'h0) begin n_fail++; $display("FAIL reset_out_data got %h want 00000000", out_data); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_single_pass;
    logic [31:0] d [3] = '{32'hA5A5A5A5, 32'h7FFFFFFF, 32'h80000000};
    logic [4:0]  a [3] = '{5'd4, 5'd4, 5'd31};
    logic [1:0]  o [3] = '{2'd0, 2'd3, 2'd1};
    logic [31:0] e [3] = '{32'h5A5A5A50, 32'h07FFFFFF, 32'h00000001};
    bit ok; int lat; logic [31:0] got;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      send(d[i], a[i], o[i], ok);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL single_accept[%0d] got timeout want accept", i); end
      run_to_valid(lat, got);
      n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL single_latency[%0d] got %0d want 1", i, lat); end
      n_checks++; if (got !== e[i]) begin n_fail++; $display("FAIL single_data[%0d] got %h want %h", i, got, e[i]); end
      @(posedge clk); #1;
      n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        n_fail++; $display("FAIL single_valid_pulse[%0d] got valid=%b ready=%b want 0/1", i, out_valid, in_ready);
      end
    end
  endtask

  task automatic test_two_pass;
    logic [31:0] d [3] = '{32'h80000001, 32'h12345678, 32'h80000000};
    logic [4:0]  a [3] = '{5'd1, 5'd0, 5'd4};
    logic [1:0]  o [3] = '{2'd2, 2'd2, 2'd3};
    logic [31:0] e [3] = '{32'h00000003, 32'h12345678, 32'hF8000000};
    int          l [3] = '{2, 1, 2};
    bit ok; int lat; logic [31:0] got;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      send(d[i], a[i], o[i], ok);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL multi_accept[%0d] got timeout want accept", i); end
      run_to_valid(lat, got);
      n_checks++; if (lat !== l[i]) begin n_fail++; $display("FAIL multi_latency[%0d] got %0d want %0d", i, lat, l[i]); end
      n_checks++; if (got !== e[i]) begin n_fail++; $display("FAIL multi_data[%0d] got %h want %h", i, got, e[i]); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_backpressure;
    bit ok; int lat; logic [31:0] got; bit stable;
    out_ready = 1'b0;
    send(32'hF0000000, 5'd8, 2'd1, ok);
    run_to_valid(lat, got);
    n_checks++; if (lat !== 1 || got !== 32'h00F00000) begin
      n_fail++; $display("FAIL bp_first got lat=%0d data=%h want lat=1 data=00f00000", lat, got);
    end
    stable = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_data !== 32'h00F00000) stable = 1'b0;
    end
    n_checks++; if (!stable) begin
      n_fail++; $display("FAIL bp_hold got valid=%b ready=%b data=%h want 1/0/00f00000", out_valid, in_ready, out_data);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 32'h00F00000) begin
      n_fail++; $display("FAIL bp_release got ready=%b valid=%b data=%h want 1/0/00f00000", in_ready, out_valid, out_data);
    end
  endtask

  task automatic test_reset_mid;
    bit ok; bit stale;
    out_ready = 1'b1;
    send(32'h0000FFFF, 5'd16, 2'd2, ok);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    n_checks++; if (out_valid !== 1'b0 || out_data !== 32'h0 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL midreset_state got valid=%b data=%h ready=%b want 0/00000000/1", out_valid, out_data, in_ready);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL midreset_in_ready got %b want 1", in_ready); end
    stale = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (out_valid !== 1'b0 || out_data !== 32'h0) stale = 1'b1;
      @(posedge clk); #1;
    end
    n_checks++; if (stale) begin n_fail++; $display("FAIL midreset_stale got valid=%b data=%h want 0/00000000", out_valid, out_data); end
  endtask

  task automatic test_back_to_back;
    bit ok1, ok2; time t1, t2; int lat; logic [31:0] got;
    out_ready = 1'b1;
    send(32'h00000001, 5'd3, 2'd0, ok1);
    t1 = $time;
    send(32'hDEADBEEF, 5'd4, 2'd1, ok2);
    t2 = $time;
    n_checks++; if (!ok1 || !ok2 || (t2 - t1) != 30) begin
      n_fail++; $display("FAIL b2b_gap got %0t want 30", t2 - t1);
    end
    run_to_valid(lat, got);
    n_checks++; if (got !== 32'h0DEADBEE) begin n_fail++; $display("FAIL b2b_data got %h want 0deadbee", got); end
    @(posedge clk); #1;
  endtask

  task automatic test_random;
    logic [31:0] d, exp; int a, op, el, lat; bit ok, seen, done, data_ok;
    for (int i = 0; i < 200; i++) begin
      d = $urandom; a = $urandom_range(0, 31); op = $urandom_range(0, 3);
      if ((i % 4) == 0) d[31] = 1'b1;
      exp = ref_model(d, a, op); el = ref_lat(d, a, op);
      send(d, 5'(a), 2'(op), ok);
      seen = 1'b0; done = 1'b0; data_ok = 1'b1; lat = -1;
      for (int c = 0; c < 40 && !done; c++) begin
        out_ready = 1'($urandom_range(0, 1));
        if (out_valid === 1'b1) begin
          if (!seen) begin seen = 1'b1; lat = c; end
          if (out_data !== exp) data_ok = 1'b0;
          if (out_ready) done = 1'b1;
        end
        @(posedge clk); #1;
      end
      n_checks++;
      if (!ok || !seen || !data_ok || lat != el || in_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL random[%0d] op=%0d d=%h amt=%0d got data=%h lat=%0d want data=%h lat=%0d",
                 i, op, d, a, out_data, lat, exp, el);
      end else begin
        $display("PASS random[%0d] op=%0d d=%h amt=%0d -> %h", i, op, d, a, exp);
      end
    end
  endtask

  initial begin
    test_reset;
    test_single_pass;
    test_two_pass;
    test_backpressure;
    test_reset_mid;
    test_back_to_back;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
